// File: rtl/word_bus_sender.sv
// Sends a captured 16-bit word as two byte transfers on an 8-bit bus, gated by request/grant.
// Outputs other than the grant-qualified strobes come straight from registers.
`default_nettype none

module word_bus_sender #(
  parameter int HIGH_FIRST = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] wordIn,
  input  logic        busGrant,
  output logic        busRequest,
  output logic [7:0]  dataOut,
  output logic        setHigh,
  output logic        setLow,
  output logic        busy,
  output logic        done
);

  localparam logic HI_FIRST = (HIGH_FIRST != 0);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND_FIRST  = 2'd1,
    SEND_SECOND = 2'd2
  } state_e;

  state_e      state_q;
  logic [15:0] word_q;
  logic        req_q;
  logic [7:0]  data_q;
  logic        hi_phase_q;  // 1 while the byte on the bus is the high byte
  logic        done_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      word_q     <= 16'h0000;
      req_q      <= 1'b0;
      data_q     <= 8'h00;
      hi_phase_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= SEND_FIRST;
            word_q     <= wordIn;
            req_q      <= 1'b1;
            data_q     <= HI_FIRST ? wordIn[15:8] : wordIn[7:0];
            hi_phase_q <= HI_FIRST;
          end
        end
        SEND_FIRST: begin
          if (busGrant) begin
            state_q    <= SEND_SECOND;
            data_q     <= HI_FIRST ? word_q[7:0] : word_q[15:8];
            hi_phase_q <= ~HI_FIRST;
          end
        end
        SEND_SECOND: begin
          if (busGrant) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            data_q     <= 8'h00;
            hi_phase_q <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          req_q      <= 1'b0;
          data_q     <= 8'h00;
          hi_phase_q <= 1'b0;
        end
      endcase
    end
  end

  // Strobes track the grant within the cycle so the receiver loads on the advancing edge.
  assign setHigh    = req_q & hi_phase_q & busGrant;
  assign setLow     = req_q & ~hi_phase_q & busGrant;
  assign busRequest = req_q;
  assign busy       = req_q;
  assign dataOut    = data_q;
  assign done       = done_q;

endmodule

`default_nettype wire
